// File: rtl/my_hack_pkg.sv
// Shared Hack instruction field positions and address width.
// Latency: none (constants only).
// Backpressure: none.
package my_hack_pkg;

  localparam int ADDR_W  = 15;

  // Instruction word field positions
  localparam int CI      = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

endpackage

// File: rtl/my_alu.sv
// Hack ALU: zero/negate conditioning on x and y, add or and, optional output negate.
// Latency: purely combinational.
// Backpressure: none.
module my_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  // Operand conditioning, function select and output negate
  always_comb begin
    x_z   = zx ? 16'h0000 : x;
    x_n   = nx ? ~x_z : x_z;
    y_z   = zy ? 16'h0000 : y;
    y_n   = ny ? ~y_z : y_z;
    f_out = f ? (x_n + y_n) : (x_n & y_n);
    out   = no ? ~f_out : f_out;
  end

  assign zr = (out == 16'h0000);
  assign ng = out[15];

endmodule

// File: rtl/my_pc.sv
// Program counter: reset to zero, load a jump target, or increment (wraps at 0x7FFF).
// Latency: one cycle, registered output.
// Backpressure: none; priority is reset > load > inc.
module my_pc
  import my_hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] in,
  output logic [ADDR_W-1:0] out
);

  // Counter update with reset > load > inc priority; increment wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end else if (inc) begin
      out <= out + 1'b1;
    end
  end

endmodule

// File: rtl/my_cpu.sv
// Single-cycle Hack-style CPU core: decode, drive my_alu from A/D, update A/D/PC.
// Latency: outM/writeM combinational in the current cycle; A, D, pc registered.
// Backpressure: none; one instruction per cycle, no stalls.
module my_cpu
  import my_hack_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instruction,
  input  logic [15:0]       inM,
  output logic [15:0]       outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [15:0] alu_y;
  logic [15:0] alu_out;
  logic [5:0]  comp;
  logic        alu_zr;
  logic        alu_ng;
  logic        is_c;
  logic        jump;

  assign is_c  = instruction[CI];
  assign comp  = instruction[COMP_HI:COMP_LO];
  assign alu_y = instruction[A_BIT] ? inM : a_reg;

  my_alu u_alu (
    .x   (d_reg),
    .y   (alu_y),
    .zx  (comp[5]),
    .nx  (comp[4]),
    .zy  (comp[3]),
    .ny  (comp[2]),
    .f   (comp[1]),
    .no  (comp[0]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  // Jump only on C-instructions; the target is the A value before this edge
  assign jump = is_c & ((instruction[J_LT] & alu_ng) |
                        (instruction[J_EQ] & alu_zr) |
                        (instruction[J_GT] & ~alu_ng & ~alu_zr));

  assign outM     = alu_out;
  assign writeM   = is_c & instruction[DEST_M] & ~reset;
  assign addressM = a_reg[ADDR_W-1:0];

  // A and D register updates; A-instructions load the whole word into A
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      d_reg <= '0;
    end else begin
      if (!is_c) begin
        a_reg <= instruction;
      end else if (instruction[DEST_A]) begin
        a_reg <= alu_out;
      end
      if (is_c && instruction[DEST_D]) begin
        d_reg <= alu_out;
      end
    end
  end

  my_pc u_pc (
    .clk   (clk),
    .reset (reset),
    .load  (jump),
    .inc   (1'b1),
    .in    (a_reg[ADDR_W-1:0]),
    .out   (pc)
  );

endmodule

// File: tb/tb_my_cpu.sv
// Testbench for my_cpu: directed program fragments plus random instruction stream.
// Latency: checks outM/writeM mid-cycle, pc/addressM just after each rising edge.
// Backpressure: none.
module tb_my_cpu;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int checks   = 0;
  int failures = 0;

  // Reference machine state
  logic [15:0] ma, md;
  logic [14:0] mpc;
  bit          known = 0;

  // Standard Hack comp encodings, index matches alu_ref meaning order
  logic [5:0] comp_tab [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
  };

  my_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Hack computation by mnemonic meaning
  function automatic logic [15:0] alu_ref(input logic [5:0] c, input logic [15:0] d,
                                          input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return 16'd0 - d;
      6'b110011: return 16'd0 - y;
      6'b011111: return d + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 16'hxxxx;
    endcase
  endfunction

  // One instruction cycle: drive, check combinational outputs, clock, check registers
  task automatic step(input logic [15:0] ins, input logic [15:0] m, input logic rst,
                      output logic [15:0] o, output logic w);
    logic [15:0] res, na, nd;
    logic [14:0] npc;
    logic        is_c, ng, zr, jmp;
    @(negedge clk);
    instruction = ins;
    inM         = m;
    reset       = rst;
    #1;
    o = outM;
    w = writeM;
    is_c = ins[15];
    res  = alu_ref(ins[11:6], md, ins[12] ? m : ma);
    ng   = res[15];
    zr   = (res == 16'd0);
    jmp  = is_c & ((ins[2] & ng) | (ins[1] & zr) | (ins[0] & !ng & !zr));
    chk("writeM", {15'd0, writeM}, {15'd0, is_c & ins[3] & !rst});
    if (known && is_c) chk("outM", outM, res);
    if (rst) begin
      na = 16'd0; nd = 16'd0; npc = 15'd0;
    end else begin
      na  = !is_c ? ins : (ins[5] ? res : ma);
      nd  = (is_c && ins[4]) ? res : md;
      npc = jmp ? ma[14:0] : mpc + 15'd1;
    end
    @(posedge clk);
    #1;
    ma = na; md = nd; mpc = npc;
    if (rst) known = 1;
    if (known) begin
      chk("pc", {1'b0, pc}, {1'b0, mpc});
      chk("addressM", {1'b0, addressM}, {1'b0, ma[14:0]});
    end
  endtask

  initial begin
    logic [15:0] o, ins;
    logic        w, r;
    logic [14:0] p;
    int          sel;
    reset = 1'b1; instruction = 16'h0000; inM = 16'h0000;

    // Reset
    step(16'h0000, 16'h0000, 1'b1, o, w);
    step(16'h0000, 16'h0000, 1'b1, o, w);
    chk("rst_pc", {1'b0, pc}, 16'd0);
    chk("rst_addr", {1'b0, addressM}, 16'd0);
    step(16'hEC10, 16'h1234, 1'b0, o, w);
    chk("rst_d_eq_a", o, 16'd0);
    chk("rst_wm", {15'd0, w}, 16'd0);
    step(16'h0000, 16'h0000, 1'b1, o, w);

    // @21 then D=A
    step(16'h0015, 16'h0000, 1'b0, o, w);
    chk("ai_pc", {1'b0, pc}, 16'd1);
    chk("ai_addr", {1'b0, addressM}, 16'd21);
    step(16'hEC10, 16'h0000, 1'b0, o, w);
    chk("da_pc", {1'b0, pc}, 16'd2);
    chk("da_out", o, 16'd21);

    // M=D+1
    step(16'hE7C8, 16'h0000, 1'b0, o, w);
    chk("mdp1_out", o, 16'd22);
    chk("mdp1_wm", {15'd0, w}, 16'd1);
    chk("mdp1_addr", {1'b0, addressM}, 16'd21);

    // AM=M-1 with A=50, inM=7
    step(16'h0032, 16'h0000, 1'b0, o, w);
    step(16'hFCA8, 16'h0007, 1'b0, o, w);
    chk("amm1_out", o, 16'd6);
    chk("amm1_wm", {15'd0, w}, 16'd1);
    chk("amm1_addr_next", {1'b0, addressM}, 16'd6);

    // D;JEQ with A=100
    step(16'h0064, 16'h0000, 1'b0, o, w);
    step(16'hEA90, 16'h0000, 1'b0, o, w);   // D=0
    step(16'hE302, 16'h0000, 1'b0, o, w);
    chk("jeq_taken", {1'b0, pc}, 16'd100);
    step(16'h0005, 16'h0000, 1'b0, o, w);
    step(16'hEC10, 16'h0000, 1'b0, o, w);   // D=5
    step(16'h0064, 16'h0000, 1'b0, o, w);
    p = pc;
    step(16'hE302, 16'h0000, 1'b0, o, w);
    chk("jeq_not", {1'b0, pc}, {1'b0, p + 15'd1});
    step(16'hEA87, 16'h0000, 1'b0, o, w);
    chk("jmp", {1'b0, pc}, 16'd100);

    // PC wrap
    step(16'h7FFF, 16'h0000, 1'b0, o, w);
    step(16'hEA87, 16'h0000, 1'b0, o, w);
    chk("to_7fff", {1'b0, pc}, 16'h7FFF);
    step(16'hEA90, 16'h0000, 1'b0, o, w);
    chk("wrap", {1'b0, pc}, 16'd0);

    // Reset beats a taken jump
    step(16'h0064, 16'h0000, 1'b0, o, w);
    step(16'hEA8F, 16'h0000, 1'b1, o, w);   // 0;JMP with M dest
    chk("rstjmp_wm", {15'd0, w}, 16'd0);
    chk("rstjmp_pc", {1'b0, pc}, 16'd0);
    chk("rstjmp_addr", {1'b0, addressM}, 16'd0);

    // Random instruction stream
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ins = {1'b0, 15'($urandom)};
      end else begin
        sel = $urandom_range(0, 17);
        ins = {1'b1, 2'($urandom), 1'($urandom), comp_tab[sel], 3'($urandom), 3'($urandom)};
      end
      r = ($urandom_range(0, 39) == 0);
      step(ins, 16'($urandom), r, o, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
